// File: rtl/layer_sched.sv
// layer_sched
//   Layer sequencer for the LeNet accelerator. A start pulse walks the layers
//   C1,S2,C3,S4,C5,FC,OL in order. For each weight layer it publishes the
//   weight-BRAM address window and holds fetch_req until fetch_done arrives.
//   Every layer then gets a one-cycle core_start and waits for core_done.
//   A per-phase watchdog moves the sequencer to ERR if FETCH or RUN hangs.
//
//   state | meaning
//   IDLE  | waiting for start, all outputs low
//   FETCH | weight window being pushed from BRAM to FIFO (fetch_req high)
//   ARM   | single cycle, core_start pulse for current layer
//   RUN   | core working on current layer, waiting for core_done
//   DONE  | all seven layers finished, done high, start re-runs from C1
//   ERR   | watchdog expired, err high, only abort or rst leave
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, abort        run control (abort is a level, beats start)
//   fetch_done          BRAM fetch of the current window finished
//   core_done           core finished the current layer
//   layer_signal        layer code 1..7, 0 when not busy
//   addr_lo, addr_hi    inclusive weight window, 0 for pooling/inactive
//   fetch_req           high throughout FETCH
//   core_start          one-cycle pulse in ARM
//   busy, done, err     status flags
module layer_sched #(
  parameter int ADDR_W = 6,
  parameter int C1_LO  = 0,
  parameter int C1_HI  = 1,
  parameter int C3_LO  = 2,
  parameter int C3_HI  = 5,
  parameter int C5_LO  = 6,
  parameter int C5_HI  = 29,
  parameter int FC_LO  = 30,
  parameter int FC_HI  = 46,
  parameter int OL_LO  = 47,
  parameter int OL_HI  = 48,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              fetch_done,
  input  logic              core_done,
  output logic [2:0]        layer_signal,
  output logic [ADDR_W-1:0] addr_lo,
  output logic [ADDR_W-1:0] addr_hi,
  output logic              fetch_req,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ARM, S_RUN, S_DONE, S_ERR
  } state_t;

  // Watchdog expires on the cycle that would bring the count to all-ones,
  // giving exactly 2**TO_W-1 cycles in a phase before ERR.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          st, st_n;
  logic [2:0]      lyr, lyr_n;
  logic [TO_W-1:0] wd, wd_n;
  logic            wd_exp;
  logic            act_n;

  function automatic logic is_weight(input logic [2:0] l);
    return (l == 3'd1) || (l == 3'd3) || (l == 3'd5) || (l == 3'd6) || (l == 3'd7);
  endfunction

  function automatic logic [ADDR_W-1:0] win_lo(input logic [2:0] l);
    case (l)
      3'd1:    return ADDR_W'(C1_LO);
      3'd3:    return ADDR_W'(C3_LO);
      3'd5:    return ADDR_W'(C5_LO);
      3'd6:    return ADDR_W'(FC_LO);
      3'd7:    return ADDR_W'(OL_LO);
      default: return '0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] win_hi(input logic [2:0] l);
    case (l)
      3'd1:    return ADDR_W'(C1_HI);
      3'd3:    return ADDR_W'(C3_HI);
      3'd5:    return ADDR_W'(C5_HI);
      3'd6:    return ADDR_W'(FC_HI);
      3'd7:    return ADDR_W'(OL_HI);
      default: return '0;
    endcase
  endfunction

  assign wd_exp = (wd == WD_LAST);

  always_comb begin
    st_n  = st;
    lyr_n = lyr;
    wd_n  = wd;
    case (st)
      S_IDLE, S_DONE: begin
        if (start) begin
          st_n  = S_FETCH;
          lyr_n = 3'd1;
        end
      end
      S_FETCH: begin
        if (fetch_done)  st_n = S_ARM;
        else if (wd_exp) st_n = S_ERR;
        else             wd_n = wd + 1'b1;
      end
      S_ARM: st_n = S_RUN;
      S_RUN: begin
        if (core_done) begin
          if (lyr == 3'd7) begin
            st_n  = S_DONE;
            lyr_n = '0;
          end else begin
            lyr_n = lyr + 3'd1;
            st_n  = is_weight(lyr + 3'd1) ? S_FETCH : S_ARM;
          end
        end else if (wd_exp) begin
          st_n = S_ERR;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      S_ERR:   st_n = S_ERR;
      default: st_n = S_IDLE;
    endcase
    if (st_n == S_ERR) lyr_n = '0;
    if (abort) begin
      st_n  = S_IDLE;
      lyr_n = '0;
    end
    if (st_n != st) wd_n = '0;
    act_n = (st_n == S_FETCH) || (st_n == S_ARM) || (st_n == S_RUN);
  end

  // Outputs are decoded from the next state so they appear on the same edge
  // as the state they describe; lyr_n is already 0 outside active states.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      lyr          <= '0;
      wd           <= '0;
      layer_signal <= '0;
      addr_lo      <= '0;
      addr_hi      <= '0;
      fetch_req    <= 1'b0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      st           <= st_n;
      lyr          <= lyr_n;
      wd           <= wd_n;
      layer_signal <= lyr_n;
      addr_lo      <= win_lo(lyr_n);
      addr_hi      <= win_hi(lyr_n);
      fetch_req    <= (st_n == S_FETCH);
      core_start   <= (st_n == S_ARM);
      busy         <= act_n;
      done         <= (st_n == S_DONE);
      err          <= (st_n == S_ERR);
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
module tb_layer_sched;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_ARM   = 2;
  localparam int P_RUN   = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  logic       clk = 1'b0;
  logic       rst, start, abort, fetch_done, core_done;
  logic [2:0] layer_signal;
  logic [5:0] addr_lo, addr_hi;
  logic       fetch_req, core_start, busy, done, err;

  int total = 0;
  int bad   = 0;

  // Weight windows indexed by layer code; pooling layers and 0 have none.
  int lo_tab[8] = '{0, 0, 0, 2, 0, 6, 30, 47};
  int hi_tab[8] = '{0, 1, 0, 5, 0, 29, 46, 48};

  layer_sched #(.TO_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fetch_done(fetch_done), .core_done(core_done),
    .layer_signal(layer_signal), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .fetch_req(fetch_req), .core_start(core_start),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit is_w(input int l);
    return (l == 1) || (l == 3) || (l == 5) || (l == 6) || (l == 7);
  endfunction

  function automatic logic [19:0] ev(input int ph, input int l);
    logic       act;
    logic [2:0] ls;
    logic [5:0] lo, hi;
    act = (ph == P_FETCH) || (ph == P_ARM) || (ph == P_RUN);
    ls  = act ? 3'(l) : 3'd0;
    lo  = (act && is_w(l)) ? 6'(lo_tab[l]) : 6'd0;
    hi  = (act && is_w(l)) ? 6'(hi_tab[l]) : 6'd0;
    return {ls, lo, hi, ph == P_FETCH, ph == P_ARM, act, ph == P_DONE, ph == P_ERR};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int ph, input int l);
    logic [19:0] obs, exp;
    obs = {layer_signal, addr_lo, addr_hi, fetch_req, core_start, busy, done, err};
    exp = ev(ph, l);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s L=%0d observed=%h expected=%h", tag, l, obs, exp);
    end
  endtask

  // Outputs currently show FETCH of layer l; answer fetch_done on cycle n.
  task automatic fetch_phase(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      chk("fetch", P_FETCH, l);
      if (i == n - 1) fetch_done = 1'b1;
      else            core_done  = 1'($urandom_range(0, 1));
      tick();
      fetch_done = 1'b0;
      core_done  = 1'b0;
    end
  endtask

  // Outputs currently show ARM of layer l; core_done answered on RUN cycle n.
  task automatic arm_run(input int l, input int n);
    chk("arm", P_ARM, l);
    core_done = 1'($urandom_range(0, 1));
    start     = 1'($urandom_range(0, 1));
    tick();
    core_done = 1'b0;
    start     = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("run", P_RUN, l);
      if (i == n - 1) begin
        core_done = 1'b1;
      end else begin
        fetch_done = 1'($urandom_range(0, 1));
        start      = 1'($urandom_range(0, 1));
      end
      tick();
      core_done  = 1'b0;
      fetch_done = 1'b0;
      start      = 1'b0;
    end
  endtask

  task automatic do_layer(input int l, input int nf, input int nr);
    if (is_w(l)) fetch_phase(l, nf);
    arm_run(l, nr);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fetch_done = 1'b0; core_done = 1'b0;
    tick(); tick();
    chk("reset", P_IDLE, 0);
    rst = 1'b0;

    // Stray handshakes in IDLE change nothing.
    fetch_done = 1'b1; core_done = 1'b1;
    tick();
    fetch_done = 1'b0; core_done = 1'b0;
    chk("idle_spurious", P_IDLE, 0);

    // Full run with fixed 5/10 answers.
    pulse_start();
    for (int l = 1; l <= 7; l++) do_layer(l, 5, 10);
    chk("done", P_DONE, 0);
    tick();
    chk("done_hold", P_DONE, 0);

    // Restart from DONE with random latencies.
    pulse_start();
    for (int l = 1; l <= 7; l++)
      do_layer(l, int'($urandom_range(1, 10)), int'($urandom_range(1, 12)));
    chk("done_rand", P_DONE, 0);

    // Watchdog: C3 fetch never answered.
    pulse_start();
    do_layer(1, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    do_layer(2, 0, int'($urandom_range(1, 6)));
    for (int i = 0; i < 15; i++) begin
      chk("wd_fetch", P_FETCH, 3);
      tick();
    end
    chk("wd_err", P_ERR, 0);
    start = 1'b1; fetch_done = 1'b1; core_done = 1'b1;
    tick();
    start = 1'b0; fetch_done = 1'b0; core_done = 1'b0;
    chk("err_sticky", P_ERR, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("err_abort", P_IDLE, 0);

    // Abort in the middle of C5 RUN, then a fresh start begins at C1.
    pulse_start();
    for (int l = 1; l <= 4; l++)
      do_layer(l, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    fetch_phase(5, int'($urandom_range(1, 6)));
    chk("c5_arm", P_ARM, 5);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("c5_run", P_RUN, 5);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run", P_IDLE, 0);
    pulse_start();
    chk("restart_c1", P_FETCH, 1);

    // Reset during FC fetch.
    fetch_phase(1, int'($urandom_range(1, 6)));
    arm_run(1, int'($urandom_range(1, 6)));
    for (int l = 2; l <= 5; l++)
      do_layer(l, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    chk("fc_fetch", P_FETCH, 6);
    tick();
    chk("fc_fetch2", P_FETCH, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", P_IDLE, 0);

    // start and abort together: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort", P_IDLE, 0);
    tick();
    chk("start_abort2", P_IDLE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
